s2p_rx: RTL and testbench
=========================

S2P_RX -- requirements
Module: s2p_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: DEPTH, 4, word FIFO depth, power of 2, minimum 2.
REQ-003 Parameter: TIMEOUT, 8, idle-cycle limit for a partial word; used only when S2P_TIMEOUT_EN is defined.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 data  input  1  serial bit from the upstream parallel-to-serial stage, MSB first.
REQ-007 vld  input  1  data qualifier; a bit is sampled only when vld=1.
REQ-008 rd  input  1  pop request for the head word.
REQ-009 dout  output  4  head word of the FIFO; 4'b0000 when empty.
REQ-010 empty  output  1  FIFO holds no words.
REQ-011 full  output  1  FIFO holds DEPTH words.
REQ-012 ovf  output  1  sticky flag: a completed word was dropped.
REQ-013 tout  output  1  sticky flag: a partial word was discarded on timeout.

Function
REQ-014 FSM states: IDLE (no bits held) and RECV (1-3 bits held); the bit counter cnt SHALL be 2 bits.
REQ-015 vld=1 SHALL shift the assembly register: sh <= {sh[2:0], data}, cnt <= cnt+1 (mod 4).
REQ-016 vld=0 SHALL hold sh and cnt; gaps between bits SHALL NOT break a word.
REQ-017 Transitions SHALL be: IDLE->RECV on vld; RECV->IDLE on vld with cnt==3; RECV->IDLE on timeout (REQ-029).
REQ-018 On vld with cnt==3, word {sh[2:0], data} SHALL be pushed on that edge.
REQ-019 A pushed word SHALL be visible on dout one cycle after its 4th bit is sampled.
REQ-020 The first pushed word is the oldest: first-in-first-out, first-word fall-through.
REQ-021 rd=1 with empty=0 SHALL pop the head word; rd with empty=1 SHALL be ignored, with no state change.
REQ-022 Push and pop in the same cycle SHALL both succeed, including when full; occupancy is unchanged.
REQ-023 Push while full without pop SHALL drop the new word, leave the FIFO contents intact and set ovf.
REQ-024 Pointers SHALL wrap modulo DEPTH; the occupancy counter SHALL be log2(DEPTH)+1 bits wide.
REQ-025 ovf and tout SHALL clear only on reset.

Reset
REQ-026 rst=1 at a clock edge SHALL set: state IDLE, cnt=0, sh=0, FIFO empty, pointers=0, dout=0, empty=1, full=0, ovf=0, tout=0.
REQ-027 Reset mid-word SHALL discard the partial bits; the next vld bit is the MSB of a new word.
REQ-028 rst SHALL take priority over vld and rd in the same cycle.

Configuration
REQ-029 With S2P_TIMEOUT_EN defined: in RECV, an idle counter SHALL increment on each vld=0 cycle and clear on vld=1. When it reaches TIMEOUT, the block SHALL discard the partial word, return to IDLE with cnt=0, and set tout.
REQ-030 Without S2P_TIMEOUT_EN, no idle counter SHALL exist, RECV SHALL wait indefinitely and tout SHALL be tied to 0.

Verification
REQ-031 Bits 1,0,1,1 on 4 consecutive vld cycles -> next cycle dout=4'b1011, empty=0; rd for 1 cycle -> empty=1, dout=4'b0000.
REQ-032 Bits 0,1,1,0 with 2 vld=0 cycles between each bit -> single word 4'b0110, no extra push.
REQ-033 Push 5 words (4'h1..4'h5), no rd, DEPTH=4 -> full=1 after the 4th, ovf=1 after the 5th; pops return 1,2,3,4.
REQ-034 FIFO full, 4th bit of word 4'hA sampled with rd=1 -> the pop returns the old head, 4'hA is queued at the tail, full stays 1, ovf=0.
REQ-035 2 bits sent, rst pulsed for 1 cycle, then bits 1,1,0,0 -> dout=4'b1100, empty=0, only one word present.
REQ-036 S2P_TIMEOUT_EN defined: 2 bits, then 8 idle cycles, then bits 0,0,1,1 -> tout=1, dout=4'b0011. Undefined: same stimulus -> dout=4'b{b0,b1,0,0}, where b0,b1 are the 2 bits sent first, the 2 later bits stay in sh, and tout=0.

Source files
------------

// File: rtl/s2p_rx.sv
// s2p_rx: serial-to-parallel receiver packing MSB-first bits into 4-bit words queued in a fall-through FIFO
//   Parameters: DEPTH (FIFO words, power of 2, >= 2), TIMEOUT (idle-cycle limit for a partial word)
//   Ports: clk, rst (sync active-high) | data, vld (serial in) | rd (pop head word)
//          dout (head word, 0 when empty), empty, full, ovf (sticky drop), tout (sticky timeout)
//   Optional build macro S2P_TIMEOUT_EN enables the partial-word idle timeout; otherwise tout is tied low.
module s2p_rx #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data,
  input  logic       vld,
  input  logic       rd,
  output logic [3:0] dout,
  output logic       empty,
  output logic       full,
  output logic       ovf,
  output logic       tout
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, RECV} state_t;
  state_t          state, state_nx;
  logic [1:0]      cnt, cnt_nx;
  // only the three most recent bits are ever needed; the fourth arrives on data
  logic [2:0]      sh, sh_nx;
  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     occ;
  logic            push, pop, wr, tmo;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("s2p_rx: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end
  assign push  = state == RECV && vld && cnt == 2'd3;
  assign pop   = rd && !empty;
  // a pop frees the slot the simultaneous push needs, so full only blocks a lone push
  assign wr    = push && (!full || pop);
  assign empty = occ == '0;
  assign full  = occ == (AW+1)'(DEPTH);
  assign dout  = empty ? 4'b0000 : mem[rp];
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    if (vld) begin
      sh_nx    = {sh[1:0], data};
      cnt_nx   = cnt + 2'd1;
      state_nx = cnt == 2'd3 ? IDLE : RECV;
    end else if (tmo) begin
      sh_nx    = '0;
      cnt_nx   = '0;
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      wp    <= '0;
      rp    <= '0;
      occ   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sh    <= sh_nx;
      wp    <= wr ? wp + AW'(1) : wp;
      rp    <= pop ? rp + AW'(1) : rp;
      occ   <= occ + (AW+1)'(wr) - (AW+1)'(pop);
      ovf   <= ovf | (push && !wr);
    end
  always_ff @(posedge clk)
    if (!rst && wr) mem[wp] <= {sh, data};
`ifdef S2P_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle;
  // fires on the vld=0 cycle that brings the idle count up to TIMEOUT
  assign tmo = state == RECV && !vld && int'(idle) == TIMEOUT - 1;
  always_ff @(posedge clk)
    if (rst) begin
      idle <= '0;
      tout <= 1'b0;
    end else begin
      idle <= (state == RECV && !vld && !tmo) ? idle + IW'(1) : '0;
      tout <= tout | tmo;
    end
`else
  assign tmo  = 1'b0;
  assign tout = 1'b0;
`endif
endmodule

// File: tb/tb_s2p_rx.sv
// tb_s2p_rx: directed bench for s2p_rx with a queue-based reference model checked every cycle
module tb_s2p_rx;
  localparam int DEPTH = 4, TIMEOUT = 8;
  logic clk = 1'b0, rst = 1'b1, data = 1'b0, vld = 1'b0, rd = 1'b0;
  logic [3:0] dout;
  logic empty, full, ovf, tout;
  int n_chk = 0, n_fail = 0;
  s2p_rx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .data(data), .vld(vld), .rd(rd),
    .dout(dout), .empty(empty), .full(full), .ovf(ovf), .tout(tout)
  );
  always #5 clk = ~clk;
  int q[$];
  int pval = 0, pbits = 0, idle = 0;
  bit m_ovf = 0, m_tout = 0, live = 0, popd;
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      pval = 0; pbits = 0; idle = 0; m_ovf = 0; m_tout = 0; live = 1;
    end else begin
      popd = rd && q.size() > 0;
      if (popd) void'(q.pop_front());
      if (vld) begin
        pval = pval * 2 + int'(data);
        pbits++;
        idle = 0;
        if (pbits == 4) begin
          if (q.size() < DEPTH) q.push_back(pval);
          else m_ovf = 1;
          pbits = 0; pval = 0;
        end
      end
`ifdef S2P_TIMEOUT_EN
      else if (pbits > 0) begin
        idle++;
        if (idle == TIMEOUT) begin
          pbits = 0; pval = 0; idle = 0; m_tout = 1;
        end
      end
`endif
    end
  end
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (live) begin
      chk("model_dout", int'(dout), q.size() > 0 ? q[0] : 0);
      chk("model_empty", int'(empty), int'(q.size() == 0));
      chk("model_full", int'(full), int'(q.size() == DEPTH));
      chk("model_ovf", int'(ovf), int'(m_ovf));
      chk("model_tout", int'(tout), int'(m_tout));
    end
  task automatic step(bit v, bit d, bit r);
    vld = v; data = d; rd = r;
    @(posedge clk);
    #2;
  endtask
  task automatic send_word(logic [3:0] w);
    for (int i = 3; i >= 0; i--) step(1'b1, w[i], 1'b0);
  endtask
  task automatic do_rst();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask
  initial begin
    step(0, 0, 0);
    do_rst();
    chk("rst_dout", int'(dout), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_tout", int'(tout), 0);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    chk("basic_dout", int'(dout), 4'b1011);
    chk("basic_empty", int'(empty), 0);
    step(0, 0, 1);
    chk("basic_pop_empty", int'(empty), 1);
    chk("basic_pop_dout", int'(dout), 0);
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(1, 1, 0); step(0, 0, 0); step(0, 0, 0);
    step(1, 1, 0); step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0);
    chk("gap_dout", int'(dout), 4'b0110);
    step(0, 0, 0); step(0, 0, 0);
    step(0, 0, 1);
    chk("gap_single_word", int'(empty), 1);
    step(0, 0, 1);
    chk("rd_empty_ignored", int'(empty), 1);
    chk("rd_empty_dout", int'(dout), 0);
    for (int w = 1; w <= 5; w++) begin
      send_word(4'(w));
      if (w == 3) chk("fill3_full", int'(full), 0);
      if (w == 4) chk("fill4_full", int'(full), 1);
      if (w == 4) chk("fill4_ovf", int'(ovf), 0);
      if (w == 5) chk("fill5_ovf", int'(ovf), 1);
    end
    for (int w = 1; w <= 4; w++) begin
      chk("drain_dout", int'(dout), w);
      step(0, 0, 1);
    end
    chk("drain_empty", int'(empty), 1);
    do_rst();
    for (int w = 6; w <= 9; w++) send_word(4'(w));
    chk("pp_pre_full", int'(full), 1);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 0, 1);
    chk("pp_full", int'(full), 1);
    chk("pp_ovf", int'(ovf), 0);
    chk("pp_head", int'(dout), 7);
    for (int w = 7; w <= 10; w++) begin
      chk("pp_drain", int'(dout), w);
      step(0, 0, 1);
    end
    chk("pp_empty", int'(empty), 1);
    step(1, 1, 0); step(1, 0, 0);
    rst = 1'b1;
    step(1, 1, 1);
    rst = 1'b0;
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 0); step(1, 0, 0);
    chk("midrst_dout", int'(dout), 4'b1100);
    chk("midrst_empty", int'(empty), 0);
    step(0, 0, 1);
    chk("midrst_one_word", int'(empty), 1);
    do_rst();
    step(1, 1, 0); step(1, 0, 0);
    repeat (8) step(0, 0, 0);
    step(1, 0, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
`ifdef S2P_TIMEOUT_EN
    chk("tmo_tout", int'(tout), 1);
    chk("tmo_dout", int'(dout), 4'b0011);
`else
    chk("tmo_tout", int'(tout), 0);
    chk("tmo_dout", int'(dout), 4'b1000);
`endif
    step(0, 0, 1);
    chk("tmo_one_word", int'(empty), 1);
    repeat (3) step(0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
